// File: rtl/program_run_controller.sv
// Run controller for CPU program tests: sequences CPU reset release,
// counts run cycles, detects termination (tohost store, ebreak, watchdog),
// emits a one-cycle memory dump strobe and exports sticky halt status.
`timescale 1ns/1ps
module program_run_controller #(
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] TOHOST_ADDR    = 32'hFFFF_FFF0,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     ebreak,
  input  logic [31:0]              pc,
  input  logic [31:0]              memory_address,
  input  logic [31:0]              memory_write,
  input  logic [3:0]               memory_byte_enable,
  input  logic                     memory_we,
  output logic                     cpu_rst_n,
  output logic                     dump,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               halt_cause,
  output logic [30:0]              exit_code,
  output logic [31:0]              halt_pc,
  output logic [COUNTER_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_TOHOST  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Terminal values of the shared HOLD/DRAIN phase counter.
  localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  // Pre-increment count seen in the last permitted RUN cycle; only
  // meaningful when the watchdog is enabled.
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
    COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic [31:0] phase_cnt;

  logic tohost_hit;
  logic ebreak_hit;
  logic timeout_hit;

  // Saturating run-cycle increment: sticks at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
    input logic [COUNTER_WIDTH-1:0] value
  );
    if (value == {COUNTER_WIDTH{1'b1}}) begin
      return value;
    end
    return value + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // A run passes on ebreak, or on tohost with a zero exit code.
  function automatic logic pass_of(
    input logic [1:0]  cause,
    input logic [30:0] code
  );
    return (cause == CAUSE_EBREAK) || ((cause == CAUSE_TOHOST) && (code == '0));
  endfunction

  // Halt event decode; feeds only registered state, never an output directly.
  always_comb begin
    tohost_hit  = memory_we && (memory_address == TOHOST_ADDR) &&
                  (memory_byte_enable == 4'b1111) && memory_write[0];
    ebreak_hit  = ebreak;
    timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HOLD;
      phase_cnt   <= '0;
      cpu_rst_n   <= 1'b0;
      dump        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      exit_code   <= '0;
      halt_pc     <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            phase_cnt <= '0;
            cpu_rst_n <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // The halt cycle itself is counted.
          cycle_count <= sat_inc(cycle_count);
          if (tohost_hit || ebreak_hit || timeout_hit) begin
            state     <= S_DRAIN;
            phase_cnt <= '0;
            dump      <= 1'b1;
            halt_pc   <= pc;
            if (tohost_hit) begin
              halt_cause <= CAUSE_TOHOST;
              exit_code  <= memory_write[31:1];
            end else if (ebreak_hit) begin
              halt_cause <= CAUSE_EBREAK;
            end else begin
              halt_cause <= CAUSE_TIMEOUT;
            end
          end
        end
        S_DRAIN: begin
          // CPU stays out of reset so its state remains observable.
          dump <= 1'b0;
          if (phase_cnt == DRAIN_LAST) begin
            state     <= S_DONE;
            phase_cnt <= '0;
            done      <= 1'b1;
            pass      <= pass_of(halt_cause, exit_code);
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        S_DONE: begin
          if (restart) begin
            state       <= S_HOLD;
            phase_cnt   <= '0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            exit_code   <= '0;
            halt_pc     <= '0;
            cycle_count <= '0;
          end
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_run_controller.sv
// Self-checking bench for program_run_controller: table-driven directed
// runs, reset/restart corner sequences and randomized runs against a
// run-level reference model.
`timescale 1ns/1ps
module tb_program_run_controller;

  localparam int          T  = 50;
  localparam logic [31:0] TH = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        ebreak = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] memory_address = '0;
  logic [31:0] memory_write = '0;
  logic [3:0]  memory_byte_enable = '0;
  logic        memory_we = 1'b0;

  logic        cpu_rst_n, dump, done, pass;
  logic [1:0]  halt_cause;
  logic [30:0] exit_code;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;

  logic        cpu_rst_n2, dump2, done2, pass2;
  logic [1:0]  halt_cause2;
  logic [30:0] exit_code2;
  logic [31:0] halt_pc2;
  logic [3:0]  cycle_count2;

  program_run_controller #(
    .RESET_CYCLES(2), .TIMEOUT_CYCLES(T), .TOHOST_ADDR(TH),
    .DRAIN_CYCLES(2), .COUNTER_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .ebreak(ebreak), .pc(pc),
    .memory_address(memory_address), .memory_write(memory_write),
    .memory_byte_enable(memory_byte_enable), .memory_we(memory_we),
    .cpu_rst_n(cpu_rst_n), .dump(dump), .done(done), .pass(pass),
    .halt_cause(halt_cause), .exit_code(exit_code), .halt_pc(halt_pc),
    .cycle_count(cycle_count)
  );

  // Watchdog disabled, narrow saturating counter, longer hold, short drain.
  program_run_controller #(
    .RESET_CYCLES(3), .TIMEOUT_CYCLES(0), .TOHOST_ADDR(TH),
    .DRAIN_CYCLES(1), .COUNTER_WIDTH(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .ebreak(ebreak), .pc(pc),
    .memory_address(memory_address), .memory_write(memory_write),
    .memory_byte_enable(memory_byte_enable), .memory_we(memory_we),
    .cpu_rst_n(cpu_rst_n2), .dump(dump2), .done(done2), .pass(pass2),
    .halt_cause(halt_cause2), .exit_code(exit_code2), .halt_pc(halt_pc2),
    .cycle_count(cycle_count2)
  );

  always #5 clk = ~clk;

  int dump_cnt = 0;
  always @(negedge clk) if (dump) dump_cnt <= dump_cnt + 1;

  typedef struct {
    logic        eb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
  } cyc_t;

  typedef struct {
    logic [1:0]  cause;
    logic [30:0] code;
    logic [31:0] hpc;
    int          count;
    logic        pass;
  } exp_t;

  typedef struct {
    int          at;
    logic        eb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
  } ev_t;

  typedef struct {
    ev_t  e1;
    ev_t  e2;
    exp_t exp;
  } vec_t;

  cyc_t stim [T];
  vec_t vecs [10];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ev_t mk_ev(input int at, input logic eb, input logic we,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] p);
    ev_t e;
    e.at = at; e.eb = eb; e.we = we; e.addr = addr; e.be = be;
    e.wdata = wdata; e.pc = p;
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] cause, input logic [30:0] code,
                                  input logic [31:0] hpc, input int count,
                                  input logic ps);
    exp_t e;
    e.cause = cause; e.code = code; e.hpc = hpc; e.count = count; e.pass = ps;
    return e;
  endfunction

  // Run-level reference: scan the RUN cycles for the first terminating
  // event, resolving coincident events by priority tohost > ebreak > timeout.
  function automatic exp_t model();
    exp_t e;
    bit   halted;
    e = mk_exp(2'd0, '0, '0, 0, 1'b0);
    halted = 0;
    for (int k = 0; k < T; k++) begin
      if (!halted) begin
        if (stim[k].we && stim[k].addr == TH && stim[k].be == 4'hF && stim[k].wdata[0]) begin
          e.cause = 2'd2; e.code = stim[k].wdata[31:1]; halted = 1;
        end else if (stim[k].eb) begin
          e.cause = 2'd1; halted = 1;
        end else if (k + 1 == T) begin
          e.cause = 2'd3; halted = 1;
        end
        if (halted) begin
          e.hpc = stim[k].pc;
          e.count = k + 1;
        end
      end
    end
    e.pass = (e.cause == 2'd1) || (e.cause == 2'd2 && e.code == 0);
    return e;
  endfunction

  task automatic drive_idle();
    ebreak = 0; memory_we = 0; memory_address = '0;
    memory_byte_enable = '0; memory_write = '0; pc = '0;
  endtask

  task automatic apply(input int k);
    ebreak = stim[k].eb; memory_we = stim[k].we; memory_address = stim[k].addr;
    memory_byte_enable = stim[k].be; memory_write = stim[k].wdata; pc = stim[k].pc;
  endtask

  task automatic fill_idle();
    for (int k = 0; k < T; k++) begin
      stim[k] = '{eb: 1'b0, we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0,
                  pc: 32'h100 + 32'(4 * k)};
    end
  endtask

  task automatic overlay(input ev_t e);
    if (e.at > 0) begin
      stim[e.at-1] = '{eb: e.eb, we: e.we, addr: e.addr, be: e.be,
                       wdata: e.wdata, pc: e.pc};
    end
  endtask

  // Bring the DUT to its first RUN cycle, via rst_n or via restart from DONE.
  task automatic start_run(input string nm, input bit use_restart);
    drive_idle();
    if (use_restart) begin
      restart = 1;
      tick();
      restart = 0;
      chk({nm, "_rs_cpu"}, cpu_rst_n, 0);
      chk({nm, "_rs_done"}, done, 0);
      chk({nm, "_rs_count"}, cycle_count, 0);
      chk({nm, "_rs_cause"}, halt_cause, 0);
    end else begin
      @(negedge clk);
      rst_n = 0;
      #1;
      chk({nm, "_rst_vals"},
          {cpu_rst_n, dump, done, pass, halt_cause, exit_code, halt_pc, cycle_count},
          '0);
      #1;
      rst_n = 1;
    end
    tick();
    chk({nm, "_hold"}, cpu_rst_n, 0);
    tick();
    chk({nm, "_run"}, cpu_rst_n, 1);
  endtask

  // Drive the stimulus up to the expected halt and check the whole epilogue.
  task automatic run_check(input string nm, input exp_t e);
    int base;
    base = dump_cnt;
    for (int k = 0; k < e.count && k < T; k++) begin
      apply(k);
      tick();
    end
    chk({nm, "_dump_edge"}, dump, 1);
    drive_idle();
    tick();
    chk({nm, "_drain"}, {done, dump}, 2'b00);
    tick();
    chk({nm, "_done"}, done, 1);
    chk({nm, "_cause"}, halt_cause, e.cause);
    chk({nm, "_exit"}, exit_code, e.code);
    chk({nm, "_hpc"}, halt_pc, e.hpc);
    chk({nm, "_count"}, cycle_count, e.count);
    chk({nm, "_pass"}, pass, e.pass);
    ebreak = 1; memory_we = 1; memory_address = TH; memory_byte_enable = 4'hF;
    memory_write = 32'h1; pc = 32'hDEAD;
    repeat (3) tick();
    drive_idle();
    chk({nm, "_frozen"}, {done, pass, halt_cause, exit_code, halt_pc, cycle_count},
        {1'b1, e.pass, e.cause, e.code, e.hpc, 32'(e.count)});
    chk({nm, "_dumps"}, dump_cnt - base, 1);
  endtask

  initial begin
    exp_t e;
    int   base;

    vecs[0] = '{e1: mk_ev(10, 1, 0, 0, 0, 0, 32'h40), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd1, 0, 32'h40, 10, 1)};
    vecs[1] = '{e1: mk_ev(5, 0, 1, TH, 4'hF, 32'h7, 32'h200), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd2, 3, 32'h200, 5, 0)};
    vecs[2] = '{e1: mk_ev(5, 0, 1, TH, 4'b0011, 32'h7, 32'h204), e2: mk_ev(12, 1, 0, 0, 0, 0, 32'h300),
                exp: mk_exp(2'd1, 0, 32'h300, 12, 1)};
    vecs[3] = '{e1: mk_ev(5, 0, 1, TH, 4'hF, 32'h6, 32'h204), e2: mk_ev(12, 1, 0, 0, 0, 0, 32'h304),
                exp: mk_exp(2'd1, 0, 32'h304, 12, 1)};
    vecs[4] = '{e1: mk_ev(7, 1, 1, TH, 4'hF, 32'h7, 32'h208), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd2, 3, 32'h208, 7, 0)};
    vecs[5] = '{e1: mk_ev(3, 0, 1, TH, 4'hF, 32'h1, 32'h20C), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd2, 0, 32'h20C, 3, 1)};
    vecs[6] = '{e1: mk_ev(0, 0, 0, 0, 0, 0, 0), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd3, 0, 32'h1C4, 50, 0)};
    vecs[7] = '{e1: mk_ev(4, 0, 1, 32'hFFFF_FFF4, 4'hF, 32'h1, 32'h210), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd3, 0, 32'h1C4, 50, 0)};
    vecs[8] = '{e1: mk_ev(4, 0, 0, TH, 4'hF, 32'h1, 32'h214), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd3, 0, 32'h1C4, 50, 0)};
    vecs[9] = '{e1: mk_ev(20, 0, 1, TH, 4'hF, 32'hFFFF_FFFF, 32'h218), e2: mk_ev(0, 0, 0, 0, 0, 0, 0),
                exp: mk_exp(2'd2, 31'h7FFF_FFFF, 32'h218, 20, 0)};

    #2;
    chk("por_vals", {cpu_rst_n, dump, done, pass, halt_cause, exit_code, halt_pc, cycle_count}, '0);

    for (int i = 0; i < 10; i++) begin
      fill_idle();
      overlay(vecs[i].e1);
      overlay(vecs[i].e2);
      start_run($sformatf("v%0d", i), (i % 2) == 1);
      run_check($sformatf("v%0d", i), vecs[i].exp);
    end

    // Reset during DRAIN cancels the dump and restores reset values.
    start_run("drst", 1);
    base = dump_cnt;
    repeat (2) tick();
    ebreak = 1; pc = 32'h80;
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    drive_idle();
    chk("drst_vals", {cpu_rst_n, dump, done, pass, halt_cause, exit_code, halt_pc, cycle_count}, '0);
    repeat (4) tick();
    chk("drst_nodump", dump_cnt - base, 0);
    chk("drst_still", {cpu_rst_n, done, halt_cause}, '0);

    // Watchdog-free, saturating instance alongside a timing-out one.
    start_run("wd", 0);
    chk("wd2_hold", cpu_rst_n2, 0);
    tick();
    chk("wd2_run", cpu_rst_n2, 1);
    repeat (70) tick();
    chk("wd2_sat", cycle_count2, 4'hF);
    chk("wd2_notdone", {done2, halt_cause2}, 3'b000);
    chk("wd1_timeout", {done, halt_cause, cycle_count}, {1'b1, 2'd3, 32'd50});
    ebreak = 1; pc = 32'h55;
    tick();
    drive_idle();
    chk("wd2_halt", {dump2, halt_cause2, halt_pc2, cycle_count2, exit_code2},
        {1'b1, 2'd1, 32'h55, 4'hF, 31'd0});
    chk("wd1_ignore", {halt_cause, cycle_count, dump}, {2'd3, 32'd50, 1'b0});
    tick();
    chk("wd2_done", {done2, pass2, dump2}, 3'b110);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < T; k++) begin
        stim[k].eb    = ($urandom_range(0, 39) == 0);
        stim[k].we    = ($urandom_range(0, 5) == 0);
        stim[k].addr  = ($urandom_range(0, 1) == 1) ? TH : $urandom;
        stim[k].be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        stim[k].wdata = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
        stim[k].pc    = $urandom;
      end
      e = model();
      start_run($sformatf("r%0d", r), (r % 3) != 0);
      run_check($sformatf("r%0d", r), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
